aq_mp_rst_ctrl: RTL and testbench

- Parametrised multi-core reset controller; the next generation of the cluster reset top.
- Synchronises the pad reset with a configurable depth and drives the CIU and clkgen resets.
- Releases each core reset in a staggered sequence, gated by a per-core enable mask.
- Adds per-core software reset pulses and late boot of cores held at power-on.
- Sits between the pads/SoC and the cluster: CIU, clkgen and core0..N-1.

---
 rtl/aq_mp_rst_ctrl.sv | 173 +++++++++++++++++
 tb/tb_aq_mp_rst_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/aq_mp_rst_ctrl.sv
// Multi-core cluster reset controller: pad reset synchroniser, staggered core
// release under an enable mask, per-core software reset pulses and late boot.
module aq_mp_rst_ctrl #(
   parameter int unsigned NUM_CORE     = 4,
   parameter int unsigned SYNC_STAGE   = 3,
   parameter int unsigned RLS_GAP      = 4,
   parameter int unsigned PULSE_CYCLES = 16
) (
   input  logic                forever_cpuclk,
   input  logic                pad_cpu_rst_b,
   input  logic                pad_yy_mbist_mode,
   input  logic                pad_yy_scan_mode,
   input  logic                pad_yy_scan_rst_b,
   input  logic                pad_yy_dft_clk_rst_b,
   input  logic [NUM_CORE-1:0] core_rls_en,
   input  logic [NUM_CORE-1:0] core_sw_rst_req,
   output logic                ciu_rst_b,
   output logic                clkgen_rst_b,
   output logic [NUM_CORE-1:0] core_rst_b,
   output logic [NUM_CORE-1:0] core_rst_busy,
   output logic                rst_seq_done
);

   localparam int unsigned GW = $clog2(RLS_GAP + 1);
   localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(RLS_GAP - 1);
   localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);

   typedef enum logic [1:0] {S_WAIT, S_SEQ, S_DONE} seq_state_t;
   typedef enum logic [1:0] {CORE_HELD, CORE_ACTIVE, CORE_SWRST} core_state_t;

   logic                  async_rst_b;
   logic [SYNC_STAGE-1:0] sync_q;
   logic                  sync_rst_b;

   seq_state_t            seq_st, seq_nxt;
   logic [GW-1:0]         gap_cnt, gap_nxt;
   logic [NUM_CORE-1:0]   pend_q, pend_nxt;
   logic [NUM_CORE-1:0]   rls;
   logic                  gap_hit;
   logic                  done_q;

   core_state_t                  core_st  [NUM_CORE];
   core_state_t                  core_nxt [NUM_CORE];
   logic [NUM_CORE-1:0][PW-1:0]  pcnt, pcnt_nxt;
   logic [NUM_CORE-1:0]          core_q, core_q_nxt;
   logic [NUM_CORE-1:0]          busy_q, busy_nxt;

   function automatic logic [NUM_CORE-1:0] lowest_bit(input logic [NUM_CORE-1:0] v);
      return v & (~v + NUM_CORE'(1));
   endfunction

   assign async_rst_b = pad_cpu_rst_b & ~pad_yy_mbist_mode;

   always_ff @(posedge forever_cpuclk or negedge async_rst_b) begin
      if (!async_rst_b) sync_q <= '0;
      else              sync_q <= {sync_q[SYNC_STAGE-2:0], 1'b1};
   end

   assign sync_rst_b = sync_q[SYNC_STAGE-1];

   // Sequencer: the WAIT exit edge already releases the first enabled core,
   // so core m rises (m+1)*RLS_GAP cycles after the synchronised reset.
   assign gap_hit = (gap_cnt == GAP_LAST);

   always_comb begin
      seq_nxt  = seq_st;
      gap_nxt  = gap_cnt;
      pend_nxt = pend_q;
      rls      = '0;
      case (seq_st)
         S_WAIT: begin
            if (gap_hit) begin
               seq_nxt  = S_SEQ;
               gap_nxt  = '0;
               rls      = lowest_bit(core_rls_en);
               pend_nxt = core_rls_en & ~rls;
            end else begin
               gap_nxt = gap_cnt + GW'(1);
            end
         end
         S_SEQ: begin
            if (pend_q == '0) begin
               seq_nxt = S_DONE;
            end else if (gap_hit) begin
               gap_nxt  = '0;
               rls      = lowest_bit(pend_q);
               pend_nxt = pend_q & ~rls;
            end else begin
               gap_nxt = gap_cnt + GW'(1);
            end
         end
         default: seq_nxt = S_DONE;
      endcase
   end

   always_ff @(posedge forever_cpuclk or negedge sync_rst_b) begin
      if (!sync_rst_b) begin
         seq_st  <= S_WAIT;
         gap_cnt <= '0;
         pend_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         seq_st  <= seq_nxt;
         gap_cnt <= gap_nxt;
         pend_q  <= pend_nxt;
         done_q  <= (seq_nxt == S_DONE);
      end
   end

   // Per-core: release, software pulse, and late boot of held cores once DONE.
   always_comb begin
      core_q_nxt = core_q;
      busy_nxt   = busy_q;
      pcnt_nxt   = pcnt;
      for (int unsigned i = 0; i < NUM_CORE; i++) begin
         core_nxt[i] = core_st[i];
         case (core_st[i])
            CORE_HELD: begin
               if (rls[i]) begin
                  core_nxt[i]   = CORE_ACTIVE;
                  core_q_nxt[i] = 1'b1;
               end else if (seq_st == S_DONE && core_sw_rst_req[i]) begin
                  core_nxt[i]   = CORE_SWRST;
                  core_q_nxt[i] = 1'b0;
                  busy_nxt[i]   = 1'b1;
                  pcnt_nxt[i]   = PULSE_LOAD;
               end
            end
            CORE_ACTIVE: begin
               if (core_sw_rst_req[i]) begin
                  core_nxt[i]   = CORE_SWRST;
                  core_q_nxt[i] = 1'b0;
                  busy_nxt[i]   = 1'b1;
                  pcnt_nxt[i]   = PULSE_LOAD;
               end
            end
            CORE_SWRST: begin
               if (pcnt[i] == PW'(1)) begin
                  core_nxt[i]   = CORE_ACTIVE;
                  core_q_nxt[i] = 1'b1;
                  busy_nxt[i]   = 1'b0;
                  pcnt_nxt[i]   = '0;
               end else begin
                  pcnt_nxt[i] = pcnt[i] - PW'(1);
               end
            end
            default: core_nxt[i] = CORE_HELD;
         endcase
      end
   end

   always_ff @(posedge forever_cpuclk or negedge sync_rst_b) begin
      if (!sync_rst_b) begin
         for (int unsigned i = 0; i < NUM_CORE; i++) core_st[i] <= CORE_HELD;
         pcnt   <= '0;
         core_q <= '0;
         busy_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CORE; i++) core_st[i] <= core_nxt[i];
         pcnt   <= pcnt_nxt;
         core_q <= core_q_nxt;
         busy_q <= busy_nxt;
      end
   end

   assign ciu_rst_b     = pad_yy_scan_mode ? pad_yy_scan_rst_b    : sync_rst_b;
   assign clkgen_rst_b  = pad_yy_scan_mode ? pad_yy_dft_clk_rst_b : sync_rst_b;
   assign core_rst_b    = pad_yy_scan_mode ? {NUM_CORE{pad_yy_scan_rst_b}} : core_q;
   assign core_rst_busy = busy_q;
   assign rst_seq_done  = done_q;

endmodule

// File: tb/tb_aq_mp_rst_ctrl.sv
// Randomised bench for aq_mp_rst_ctrl against an event-time reference model
// (release edges, done edge and pulse end edges computed arithmetically).
module tb_aq_mp_rst_ctrl;

   localparam int NC  = 4;
   localparam int SS  = 3;
   localparam int GAP = 4;
   localparam int PL  = 16;
   localparam int BIG = 1 << 30;

   logic          clk = 1'b0;
   logic          pad_cpu_rst_b;
   logic          pad_yy_mbist_mode;
   logic          pad_yy_scan_mode;
   logic          pad_yy_scan_rst_b;
   logic          pad_yy_dft_clk_rst_b;
   logic [NC-1:0] core_rls_en;
   logic [NC-1:0] core_sw_rst_req;
   logic          ciu_rst_b;
   logic          clkgen_rst_b;
   logic [NC-1:0] core_rst_b;
   logic [NC-1:0] core_rst_busy;
   logic          rst_seq_done;

   aq_mp_rst_ctrl #(
      .NUM_CORE     (NC),
      .SYNC_STAGE   (SS),
      .RLS_GAP      (GAP),
      .PULSE_CYCLES (PL)
   ) dut (
      .forever_cpuclk       (clk),
      .pad_cpu_rst_b        (pad_cpu_rst_b),
      .pad_yy_mbist_mode    (pad_yy_mbist_mode),
      .pad_yy_scan_mode     (pad_yy_scan_mode),
      .pad_yy_scan_rst_b    (pad_yy_scan_rst_b),
      .pad_yy_dft_clk_rst_b (pad_yy_dft_clk_rst_b),
      .core_rls_en          (core_rls_en),
      .core_sw_rst_req      (core_sw_rst_req),
      .ciu_rst_b            (ciu_rst_b),
      .clkgen_rst_b         (clkgen_rst_b),
      .core_rst_b           (core_rst_b),
      .core_rst_busy        (core_rst_busy),
      .rst_seq_done         (rst_seq_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: edges counted from the synchronised release (e = 0).
   int sync_cnt, e, done_e;
   int rel_e    [NC];
   int pend_end [NC];
   bit up       [NC];
   bit inp      [NC];
   int req_left [NC];

   function automatic bit async_ok();
      return pad_cpu_rst_b && !pad_yy_mbist_mode;
   endfunction

   function automatic void model_clear();
      sync_cnt = 0;
      e        = 0;
      done_e   = BIG;
      for (int i = 0; i < NC; i++) begin
         rel_e[i]    = BIG;
         pend_end[i] = 0;
         up[i]       = 1'b0;
         inp[i]      = 1'b0;
      end
   endfunction

   function automatic void model_edge();
      int m;
      if (!async_ok()) begin
         model_clear();
         return;
      end
      if (sync_cnt < SS) begin
         sync_cnt++;
         e = 0;
         return;
      end
      e++;
      if (e == GAP) begin
         m = 0;
         for (int i = 0; i < NC; i++)
            if (core_rls_en[i]) begin
               rel_e[i] = (m + 1) * GAP;
               m++;
            end
         done_e = ((m == 0) ? 1 : m) * GAP + 1;
      end
      for (int i = 0; i < NC; i++) begin
         if (inp[i]) begin
            if (e == pend_end[i]) begin
               inp[i] = 1'b0;
               up[i]  = 1'b1;
            end
         end else if (core_sw_rst_req[i] && (up[i] || e > done_e)) begin
            inp[i]      = 1'b1;
            pend_end[i] = e + PL;
         end else if (e == rel_e[i]) begin
            up[i] = 1'b1;
         end
      end
   endfunction

   task automatic check_all();
      bit            up_s;
      logic [NC-1:0] cexp, bexp;
      up_s = (sync_cnt == SS);
      for (int i = 0; i < NC; i++) begin
         cexp[i] = pad_yy_scan_mode ? pad_yy_scan_rst_b : (up_s && up[i] && !inp[i]);
         bexp[i] = inp[i];
      end
      chk("ciu_rst_b",    32'(ciu_rst_b),     32'(pad_yy_scan_mode ? pad_yy_scan_rst_b : up_s));
      chk("clkgen_rst_b", 32'(clkgen_rst_b),  32'(pad_yy_scan_mode ? pad_yy_dft_clk_rst_b : up_s));
      chk("core_rst_b",   32'(core_rst_b),    32'(cexp));
      chk("core_busy",    32'(core_rst_busy), 32'(bexp));
      chk("seq_done",     32'(rst_seq_done),  32'(up_s && e >= done_e));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive_random(input bit scan_rand, input bit en_rand);
      for (int i = 0; i < NC; i++) begin
         if (req_left[i] > 0) begin
            core_sw_rst_req[i] = 1'b1;
            req_left[i]--;
         end else begin
            core_sw_rst_req[i] = 1'b0;
            if ($urandom_range(0, 24) == 0) req_left[i] = $urandom_range(1, 40);
         end
      end
      pad_yy_scan_rst_b    = 1'($urandom);
      pad_yy_dft_clk_rst_b = 1'($urandom);
      pad_yy_scan_mode     = scan_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (en_rand && $urandom_range(0, 9) == 0) core_rls_en = NC'($urandom);
   endtask

   initial begin
      int abort_at;
      pad_cpu_rst_b        = 1'b0;
      pad_yy_mbist_mode    = 1'b0;
      pad_yy_scan_mode     = 1'b0;
      pad_yy_scan_rst_b    = 1'b0;
      pad_yy_dft_clk_rst_b = 1'b0;
      core_rls_en          = '0;
      core_sw_rst_req      = '0;
      for (int i = 0; i < NC; i++) req_left[i] = 0;
      model_clear();
      repeat (2) tick();

      for (int run = 0; run < 8; run++) begin
         // asynchronous assertion from whatever state the previous run left
         pad_yy_scan_mode = 1'b0;
         core_sw_rst_req  = '0;
         for (int i = 0; i < NC; i++) req_left[i] = 0;
         pad_cpu_rst_b = 1'b0;
         #1;
         model_clear();
         check_all();
         repeat (3) tick();

         case (run)
            0:       core_rls_en = 4'b1111;
            1:       core_rls_en = 4'b1010;
            2:       core_rls_en = 4'b0000;
            default: core_rls_en = NC'($urandom);
         endcase
         pad_yy_mbist_mode = (run == 5);
         pad_cpu_rst_b     = 1'b1;
         #1;
         check_all();
         if (run == 5) begin
            repeat (10) tick();
            pad_yy_mbist_mode = 1'b0;
            #1;
            check_all();
         end

         abort_at = (run == 3 || run == 6) ? int'($urandom_range(8, 60)) : BIG;
         for (int c = 0; c < 200; c++) begin
            tick();
            drive_random(run == 4 || run == 7, run >= 3);
            if (c == abort_at)     pad_cpu_rst_b = 1'b0;
            if (c == abort_at + 2) pad_cpu_rst_b = 1'b1;
            #1;
            if (!async_ok()) model_clear();
            check_all();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
